// File: rtl/cd_sector_pkg.sv
// Shared constants, FSM state encoding and header record for the CDIC sector receiver.
// Word indices count 16-bit words from the start of a raw sector.
package cd_sector_pkg;

   localparam logic [15:0] SYNC_FIRST = 16'hFF00;
   localparam logic [15:0] SYNC_MID   = 16'hFFFF;
   localparam logic [15:0] SYNC_LAST  = 16'h00FF;

   localparam logic [10:0] SYNC_END     = 11'd5;
   localparam logic [10:0] HDR_MIN_SEC  = 11'd6;
   localparam logic [10:0] HDR_FRM_MODE = 11'd7;
   localparam logic [10:0] SUB_FILE_CH  = 11'd8;
   localparam logic [10:0] SUB_SM_CI    = 11'd9;
   localparam logic [10:0] DATA_START   = 11'd12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_HEADER,
      ST_DATA,
      ST_SUBCODE,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
      logic [7:0] frame;
      logic [7:0] mode;
      logic [7:0] file;
      logic [7:0] channel;
      logic [7:0] submode;
      logic [7:0] coding;
   } hdr_t;

   function automatic logic [15:0] sync_word(input logic [10:0] idx);
      if (idx == 11'd0)
         return SYNC_FIRST;
      else if (idx == SYNC_END)
         return SYNC_LAST;
      else
         return SYNC_MID;
   endfunction

endpackage

// File: rtl/cd_subcode_regfile.sv
// Double-buffered subchannel store: words land in a shadow bank while a sector streams
// and become readable only after commit, so readers never see a half-updated sector.
module cd_subcode_regfile #(
   parameter int DEPTH = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [3:0]  wr_idx,
   input  logic [15:0] wr_data,
   input  logic        commit,
   input  logic [3:0]  rd_idx,
   output logic [15:0] rd_data
);

   logic [15:0] shadow_q [DEPTH];
   logic [15:0] live_q   [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow_q[i] <= 16'h0000;
            live_q[i]   <= 16'h0000;
         end
         rd_data <= 16'h0000;
      end else begin
         if (wr_en && (32'(wr_idx) < DEPTH))
            shadow_q[wr_idx] <= wr_data;
         if (commit)
            live_q <= shadow_q;
         // Indices past the captured range read as zero.
         rd_data <= (32'(rd_idx) < DEPTH) ? live_q[rd_idx] : 16'h0000;
      end
   end

endmodule

// File: rtl/cdic_sector_receiver.sv
// Writes the paced sector-cache word stream into the CDIC buffer RAM, checks sync, captures
// header/subheader and reports per-sector status. CD_SUBCODE_CAPTURE_EN diverts subchannel words to a register file.
module cdic_sector_receiver
   import cd_sector_pkg::*;
#(
   parameter int BUF_ADDR_WIDTH = 13,
   parameter int SECTOR_WORDS   = 1188,
   parameter int SUBCODE_WORDS  = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [BUF_ADDR_WIDTH-1:0] buf_base,
   input  logic [15:0]               cd_data,
   input  logic                      cd_data_valid,
   input  logic                      sector_delivered,
   output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
   output logic [15:0]               buf_data,
   output logic                      buf_we,
   output logic [7:0]                hdr_min,
   output logic [7:0]                hdr_sec,
   output logic [7:0]                hdr_frame,
   output logic [7:0]                hdr_mode,
   output logic [7:0]                sub_file,
   output logic [7:0]                sub_channel,
   output logic [7:0]                sub_submode,
   output logic [7:0]                sub_coding,
   output logic                      sector_done,
   output logic                      sync_error,
   output logic                      length_error,
   input  logic [3:0]                subcode_idx,
   output logic [15:0]               subcode_data
);

   localparam logic [10:0] SW        = 11'(SECTOR_WORDS);
   localparam logic [10:0] SUB_START = 11'(SECTOR_WORDS - SUBCODE_WORDS);

   state_t                    state, next_state, region;
   logic [10:0]               word_idx, idx_inc;
   logic [BUF_ADDR_WIDTH-1:0] base_q, base_sel;
   logic                      accept, deliver, take, publish;
   logic                      sync_mis, keep_word;
   logic                      sync_err_acc, len_err_acc;
   hdr_t                      shadow, hdr_pub;

   always_comb begin
      accept   = enable & cd_data_valid;
      deliver  = enable & sector_delivered;
      idx_inc  = (word_idx == 11'h7FF) ? word_idx : word_idx + 11'd1;
      base_sel = (state == ST_IDLE) ? buf_base : base_q;
      sync_mis = (word_idx <= SYNC_END) && (cd_data != sync_word(word_idx));
`ifdef CD_SUBCODE_CAPTURE_EN
      keep_word = (word_idx < SUB_START);
`else
      keep_word = (word_idx < SW);
`endif
      // The state names the region the next word will fall in.
      if (idx_inc <= SYNC_END)
         region = ST_SYNC;
      else if (idx_inc < DATA_START)
         region = ST_HEADER;
      else if (idx_inc < SUB_START)
         region = ST_DATA;
      else
         region = ST_SUBCODE;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      take       = 1'b0;
      publish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               take       = 1'b1;
               next_state = deliver ? ST_DONE : region;
            end
         end
         ST_SYNC, ST_HEADER, ST_DATA, ST_SUBCODE: begin
            if (accept) begin
               take       = 1'b1;
               next_state = region;
            end
            // A word coinciding with the close is still taken above.
            if (deliver)
               next_state = ST_DONE;
         end
         ST_DONE: begin
            publish    = 1'b1;
            next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx     <= 11'd0;
         base_q       <= '0;
         shadow       <= '0;
         hdr_pub      <= '0;
         sync_err_acc <= 1'b0;
         len_err_acc  <= 1'b0;
         buf_we       <= 1'b0;
         buf_addr     <= '0;
         buf_data     <= 16'h0000;
         sector_done  <= 1'b0;
         sync_error   <= 1'b0;
         length_error <= 1'b0;
      end else begin
         buf_we      <= 1'b0;
         sector_done <= 1'b0;
         if (take) begin
            word_idx <= idx_inc;
            if (state == ST_IDLE) begin
               base_q       <= buf_base;
               shadow       <= '0;
               sync_err_acc <= sync_mis;
               len_err_acc  <= 1'b0;
            end else begin
               if (sync_mis)
                  sync_err_acc <= 1'b1;
               if (word_idx >= SW)
                  len_err_acc <= 1'b1;
            end
            if (keep_word) begin
               buf_we   <= 1'b1;
               buf_addr <= base_sel + BUF_ADDR_WIDTH'(word_idx);
               buf_data <= cd_data;
            end
            case (word_idx)
               HDR_MIN_SEC:  begin shadow.min     <= cd_data[7:0]; shadow.sec     <= cd_data[15:8]; end
               HDR_FRM_MODE: begin shadow.frame   <= cd_data[7:0]; shadow.mode    <= cd_data[15:8]; end
               SUB_FILE_CH:  begin shadow.file    <= cd_data[7:0]; shadow.channel <= cd_data[15:8]; end
               SUB_SM_CI:    begin shadow.submode <= cd_data[7:0]; shadow.coding  <= cd_data[15:8]; end
               default: ;
            endcase
         end
         if (publish) begin
            hdr_pub      <= shadow;
            sector_done  <= 1'b1;
            sync_error   <= sync_err_acc;
            length_error <= len_err_acc | (word_idx != SW);
            word_idx     <= 11'd0;
         end
      end
   end

   assign hdr_min     = hdr_pub.min;
   assign hdr_sec     = hdr_pub.sec;
   assign hdr_frame   = hdr_pub.frame;
   assign hdr_mode    = hdr_pub.mode;
   assign sub_file    = hdr_pub.file;
   assign sub_channel = hdr_pub.channel;
   assign sub_submode = hdr_pub.submode;
   assign sub_coding  = hdr_pub.coding;

`ifdef CD_SUBCODE_CAPTURE_EN
   cd_subcode_regfile #(
      .DEPTH(SUBCODE_WORDS)
   ) u_subcode (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (take && (word_idx >= SUB_START) && (word_idx < SW)),
      .wr_idx  (4'(word_idx - SUB_START)),
      .wr_data (cd_data),
      .commit  (publish),
      .rd_idx  (subcode_idx),
      .rd_data (subcode_data)
   );
`else
   logic unused_subcode_idx;
   assign unused_subcode_idx = ^subcode_idx;
   assign subcode_data       = 16'h0000;
`endif

endmodule

// File: tb/tb_cdic_sector_receiver.sv
// Directed bench for cdic_sector_receiver: drivers push expected buffer writes and sector
// completions into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cdic_sector_receiver;

`ifdef CD_SUBCODE_CAPTURE_EN
   localparam bit SUBCAP = 1'b1;
`else
   localparam bit SUBCAP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] hdr;
      logic [31:0] sub;
      logic        se;
      logic        le;
      logic [31:0] cyc;
   } done_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [12:0] buf_base = 13'h0000;
   logic [15:0] cd_data = 16'h0000;
   logic        cd_data_valid = 1'b0;
   logic        sector_delivered = 1'b0;
   logic [3:0]  subcode_idx = 4'd0;
   logic [12:0] buf_addr;
   logic [15:0] buf_data, subcode_data;
   logic        buf_we, sector_done, sync_error, length_error;
   logic [7:0]  hdr_min, hdr_sec, hdr_frame, hdr_mode;
   logic [7:0]  sub_file, sub_channel, sub_submode, sub_coding;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [28:0] exp_q[$];
   done_t       done_q[$];
   logic [31:0] pub_hdr = '0;
   logic [31:0] pub_sub = '0;
   logic [1:0]  pub_st  = '0;

   cdic_sector_receiver dut (
      .clk(clk), .reset(reset), .enable(enable), .buf_base(buf_base),
      .cd_data(cd_data), .cd_data_valid(cd_data_valid), .sector_delivered(sector_delivered),
      .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
      .hdr_min(hdr_min), .hdr_sec(hdr_sec), .hdr_frame(hdr_frame), .hdr_mode(hdr_mode),
      .sub_file(sub_file), .sub_channel(sub_channel), .sub_submode(sub_submode), .sub_coding(sub_coding),
      .sector_done(sector_done), .sync_error(sync_error), .length_error(length_error),
      .subcode_idx(subcode_idx), .subcode_data(subcode_data)
   );

   // Clock and reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // hdr = {min,sec,frame,mode}; sub = {file,channel,submode,coding}
   function automatic logic [15:0] word_of(input int i, input logic [31:0] hdr, input logic [31:0] sub);
      case (i)
         0:         return 16'hFF00;
         1, 2, 3, 4: return 16'hFFFF;
         5:         return 16'h00FF;
         6:         return {hdr[23:16], hdr[31:24]};
         7:         return {hdr[7:0], hdr[15:8]};
         8, 10:     return {sub[23:16], sub[31:24]};
         9, 11:     return {sub[7:0], sub[15:8]};
         default: begin
            if (i >= 1176 && i < 1188) return 16'hA000 + 16'(i - 1176);
            else return 16'(i * 37) ^ hdr[15:0];
         end
      endcase
   endfunction

   // Driver tasks: entered and left on a negedge
   task automatic send_word(input logic [15:0] w);
      cd_data = w;
      cd_data_valid = 1'b1;
      @(negedge clk);
      cd_data_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic push_done(input logic [31:0] hdr, input logic [31:0] sub, input logic se, input logic le);
      done_t d;
      d.hdr = hdr; d.sub = sub; d.se = se; d.le = le;
      d.cyc = 32'(cyc + 2);
      done_q.push_back(d);
   endtask

   task automatic send_sector(input logic [12:0] base, input logic [31:0] hdr, input logic [31:0] sub,
                              input int nwords, input int bad_idx, input bit coincide,
                              input bit pause, input int abort_at);
      logic [15:0] w;
      buf_base = base;
      for (int i = 0; i < nwords; i++) begin
         if (i == abort_at) begin
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            pub_hdr = '0; pub_sub = '0; pub_st = '0;
            return;
         end
         if (pause && i == 300) begin
            enable = 1'b0;
            cd_data = 16'h1234; cd_data_valid = 1'b1; sector_delivered = 1'b1;
            @(negedge clk);
            cd_data_valid = 1'b0; sector_delivered = 1'b0;
            repeat (4) @(negedge clk);
            enable = 1'b1;
         end
         if (i == 600) begin
            chk("hold_hdr", {hdr_min, hdr_sec, hdr_frame, hdr_mode}, pub_hdr);
            chk("hold_sub", {sub_file, sub_channel, sub_submode, sub_coding}, pub_sub);
            chk("hold_status", {30'd0, sync_error, length_error}, {30'd0, pub_st});
         end
         w = (i == bad_idx) ? 16'hFFFE : word_of(i, hdr, sub);
         if (i < 1188 && !(SUBCAP && i >= 1176))
            exp_q.push_back({base + 13'(i), w});
         if (coincide && i == nwords - 1) begin
            cd_data = w; cd_data_valid = 1'b1; sector_delivered = 1'b1;
            push_done(hdr, sub, bad_idx >= 0, nwords != 1188);
            @(negedge clk);
            cd_data_valid = 1'b0; sector_delivered = 1'b0;
            @(negedge clk);
            return;
         end
         send_word(w);
         // The base must have been latched on word 0.
         if (i == 0) buf_base = 13'h1555;
      end
      sector_delivered = 1'b1;
      push_done(hdr, sub, bad_idx >= 0, nwords != 1188);
      @(negedge clk);
      sector_delivered = 1'b0;
      @(negedge clk);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (buf_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write_addr", {19'd0, buf_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [28:0] e;
            e = exp_q.pop_front();
            chk("write_addr", {19'd0, buf_addr}, {19'd0, e[28:16]});
            chk("write_data", {16'd0, buf_data}, {16'd0, e[15:0]});
         end
      end
      if (sector_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_sector_done", 32'd1, 32'd0);
         end else begin
            done_t d;
            d = done_q.pop_front();
            chk("done_cycle", 32'(cyc), d.cyc);
            chk("done_hdr", {hdr_min, hdr_sec, hdr_frame, hdr_mode}, d.hdr);
            chk("done_sub", {sub_file, sub_channel, sub_submode, sub_coding}, d.sub);
            chk("done_status", {30'd0, sync_error, length_error}, {30'd0, d.se, d.le});
            pub_hdr = d.hdr; pub_sub = d.sub; pub_st = {d.se, d.le};
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_buf_we", {31'd0, buf_we}, 32'd0);
      chk("rst_buf_addr", {19'd0, buf_addr}, 32'd0);
      chk("rst_buf_data", {16'd0, buf_data}, 32'd0);
      chk("rst_hdr", {hdr_min, hdr_sec, hdr_frame, hdr_mode}, 32'd0);
      chk("rst_sub", {sub_file, sub_channel, sub_submode, sub_coding}, 32'd0);
      chk("rst_status", {29'd0, sector_done, sync_error, length_error}, 32'd0);
      chk("rst_subcode", {16'd0, subcode_data}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // sector_delivered with no words must not pulse sector_done
      sector_delivered = 1'b1;
      @(negedge clk);
      sector_delivered = 1'b0;
      repeat (4) @(negedge clk);

      send_sector(13'h0000, 32'h00021602, 32'h01000800, 1188, -1, 1'b0, 1'b0, -1);

      subcode_idx = 4'd5;
      @(negedge clk);
      chk("subcode_idx5", {16'd0, subcode_data}, SUBCAP ? 32'h0000A005 : 32'd0);
      subcode_idx = 4'd13;
      @(negedge clk);
      chk("subcode_idx13", {16'd0, subcode_data}, 32'd0);

      // Back-to-back with a bad sync word
      send_sector(13'h0800, 32'h00021702, 32'h01016401, 1188, 3, 1'b0, 1'b0, -1);
      send_sector(13'h0100, 32'h00031002, 32'h02000000, 1000, -1, 1'b0, 1'b0, -1);
      send_sector(13'h0200, 32'h00031102, 32'h03000000, 1190, -1, 1'b0, 1'b0, -1);
      send_sector(13'h0300, 32'h00031202, 32'h04000000, 1188, -1, 1'b0, 1'b0, 600);
      send_sector(13'h0400, 32'h12345601, 32'h05060708, 1188, -1, 1'b1, 1'b1, -1);

      repeat (10) @(negedge clk);
      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
      chk("dones_outstanding", 32'(done_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdic_sector_receiver.md
# cdic_sector_receiver

Consumes the paced 16-bit word stream produced by the HPS CD sector cache and writes each 1188-word raw sector (2352 bytes plus 12 subchannel words) into the CDIC sector buffer RAM. While writing, it checks the 12-byte sync pattern, extracts the Mode 1/2 header and the Mode 2 subheader, and reports completion with status flags. It sits directly between the sector cache and the CDIC buffer/register logic.

## Interface
- BUF_ADDR_WIDTH, 13: width of the buffer RAM word address; upper bits come from buf_base.
- SECTOR_WORDS, 1188: expected words per sector, including subchannel.
- SUBCODE_WORDS, 12: trailing subchannel words.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = accept words; 0 = ignore cd_data_valid and sector_delivered
- buf_base  in  BUF_ADDR_WIDTH  sector base address; latched on the first word of each sector
- cd_data  in  16  stream word; the earlier byte is in [7:0]
- cd_data_valid  in  1  one-cycle word strobe; at least 3 idle cycles between strobes
- sector_delivered  in  1  one-cycle end-of-sector pulse; always after the last strobe
- buf_addr  out  BUF_ADDR_WIDTH  buffer write address
- buf_data  out  16  buffer write data
- buf_we  out  1  buffer write strobe
- hdr_min, hdr_sec, hdr_frame, hdr_mode  out  8 each  header bytes (BCD MSF, mode)
- sub_file, sub_channel, sub_submode, sub_coding  out  8 each  subheader bytes
- sector_done  out  1  one-cycle pulse; header, subheader and status outputs are valid from this cycle
- sync_error  out  1  the sync pattern mismatched in the last completed sector
- length_error  out  1  the word count was not SECTOR_WORDS in the last completed sector
- subcode_idx  in  4  subchannel word select
- subcode_data  out  16  selected captured subchannel word

## Operation
- FSM states: IDLE, SYNC (words 0–5), HEADER (6–11), DATA (12..SECTOR_WORDS-SUBCODE_WORDS-1), SUBCODE, DONE.
- 11-bit word counter word_idx; it resets to 0 in IDLE and after DONE.
- IDLE → SYNC on the first accepted strobe. That strobe also latches buf_base into base_q and clears the sync_error and length_error accumulators.
- Expected sync words: 0xFF00, four words of 0xFFFF, then 0x00FF. Any mismatch sets sync_err_acc.
- Header and subheader words:
  - word 6: [7:0] = min, [15:8] = sec
  - word 7: [7:0] = frame, [15:8] = mode
  - word 8: [7:0] = file, [15:8] = channel
  - word 9: [7:0] = submode, [15:8] = coding
  - words 10–11 (subheader copy) are written to the buffer only and are not compared.
- These bytes are captured into shadow registers. The shadows are copied to the hdr_*/sub_* outputs only at DONE, so the outputs hold the previous sector's values while a new sector streams.
- Every accepted word is written to buf_addr = base_q + word_idx, except in SUBCODE when CD_SUBCODE_CAPTURE_EN is defined.
- Words with word_idx ≥ SECTOR_WORDS are dropped (no write) and set len_err_acc.
- Any state other than IDLE/DONE → DONE on sector_delivered. At that point word_idx ≠ SECTOR_WORDS sets length_error.
- DONE pulses sector_done, publishes all status, and returns to IDLE.
- sector_delivered in IDLE (no words received) is ignored: no pulse.
- If cd_data_valid and sector_delivered coincide (protocol violation), the word is accepted first, then the sector closes.
- enable = 0 mid-sector freezes the FSM; strobes and sector_delivered are ignored, and the sector resumes on re-enable.
- reset mid-sector: FSM → IDLE, word_idx → 0, no sector_done, partial shadows discarded.

## Timing
- Reset values: buf_we = 0, buf_addr = 0, buf_data = 0, all hdr_*/sub_* = 0, sector_done = 0, sync_error = 0, length_error = 0, subcode_data = 0.
- buf_we/buf_addr/buf_data are registered: one cycle after the accepted cd_data_valid.
- sector_done asserts exactly 2 cycles after sector_delivered: one cycle to enter DONE, one to publish. Status and header outputs change in the same cycle as sector_done.
- The next sector's first strobe may arrive one cycle after sector_done; IDLE must accept it.
- Throughput: one word per strobe; no backpressure exists, and the buffer RAM must accept buf_we every cycle.
- subcode_data is registered: 1-cycle latency from subcode_idx.

## Configuration
- CD_SUBCODE_CAPTURE_EN defined:
  - SUBCODE words are stored in a 12×16 register file and are not written to the buffer.
  - subcode_data returns the captured words; indices ≥ 12 read 0.
  - The file updates only at DONE (double-buffered).
- Undefined:
  - SUBCODE words are written to the buffer like DATA.
  - subcode_data is tied to 0 and no register file is built.

## Structure
- Package cd_sector_pkg holds:
  - constants: sync words, word indices (SYNC_END = 5, HDR_MIN_SEC = 6, HDR_FRM_MODE = 7, SUB_FILE_CH = 8, SUB_SM_CI = 9, DATA_START = 12)
  - the FSM state enum
  - a packed header/subheader struct
- Sub-module cd_subcode_regfile: double-buffered 12×16 storage, instantiated only under CD_SUBCODE_CAPTURE_EN.

## Test plan
- Nominal sector, buf_base = 0x0000 and MSF 00:02:16 mode 2:
  - 1188 writes at addresses 0x000–0x4A3 (0x000–0x497 with the macro)
  - sector_done 2 cycles after sector_delivered, with hdr_min = 0x00, hdr_sec = 0x02, hdr_frame = 0x16, hdr_mode = 0x02
  - sync_error = 0, length_error = 0
- Word 3 = 0xFFFE → sync_error = 1 at sector_done; all 1188 words still written.
- Only 1000 words, then sector_delivered → length_error = 1. A sector of 1190 words → the last 2 are not written and length_error = 1.
- Two back-to-back sectors with buf_base 0x0000 then 0x0800 → the second sector's writes start at 0x0800. Header outputs hold sector 1's values until the second sector_done.
- Reset asserted at word 600, then a full sector → no sector_done for the aborted sector; the following sector completes cleanly.
- With the macro, subchannel words 0xA000–0xA00B → subcode_idx = 5 gives 0xA005 one cycle later, and subcode_idx = 13 gives 0.
